// File: rtl/lb_window9x9.sv
// lb_window9x9 -- raster-order pixel stream to 9x9 sliding windows (stride 1).
// Eight row line buffers plus a 9x9 shift register build each window, which is
// presented as one flat 81-element vector; element k = r*9+c, with r counted
// from the oldest row and c from the left. A window is emitted one clock after
// the pixel that completes it is accepted. out_row/out_col give the position of
// element 80.
// Optional build macro: LB_BINARIZE_EN. When it is defined, each accepted pixel
// is thresholded against BIN_THRESH before it is stored.
module lb_window9x9 #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int PIX_W      = 7,
  parameter int WIN        = 9,
  parameter int BIN_THRESH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [PIX_W-1:0]         in_pix,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [81*PIX_W-1:0]      out_win,
  output logic [7:0]               out_row,
  output logic [7:0]               out_col
);

  localparam int         NE       = WIN * WIN;
  localparam int         NL       = WIN - 1;
  localparam int         AW       = $clog2(IMG_W);
  localparam logic [7:0] COL_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);
  localparam logic [7:0] EDGE     = 8'(WIN - 1);

  logic [7:0]          col_r, row_r;
  logic [7:0]          pos_col_s, pos_row_s, nxt_col_s, nxt_row_s;
  logic [AW-1:0]       addr_s;
  logic                accept_s, done_s;
  logic [PIX_W-1:0]    pix_s;
  logic [PIX_W-1:0]    lb_r [NL][IMG_W];
  logic [PIX_W-1:0]    column_s [WIN];
  logic [NE*PIX_W-1:0] win_r, win_nxt_s;
  logic                out_valid_r;
  logic [7:0]          out_row_r, out_col_r;

  // The stage accepts a pixel whenever the output slot is free or is being drained.
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  assign out_valid = out_valid_r;
  assign out_win   = win_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;

  // Pixel conditioning ahead of storage: optional threshold to all-ones or zero.
  always_comb begin
    pix_s = in_pix;
`ifdef LB_BINARIZE_EN
    if ({{(32-PIX_W){1'b0}}, in_pix} >= $unsigned(BIN_THRESH)) begin
      pix_s = {PIX_W{1'b1}};
    end else begin
      pix_s = {PIX_W{1'b0}};
    end
`endif
  end

  // Position of the pixel being offered (SOF forces it to 0,0) and the position that follows it.
  always_comb begin
    pos_col_s = col_r;
    pos_row_s = row_r;
    nxt_col_s = 8'd0;
    nxt_row_s = 8'd0;
    if (in_sof) begin
      pos_col_s = 8'd0;
      pos_row_s = 8'd0;
    end else begin
      pos_col_s = col_r;
      pos_row_s = row_r;
    end
    if (pos_col_s == COL_LAST) begin
      nxt_col_s = 8'd0;
      if (pos_row_s == ROW_LAST) begin
        nxt_row_s = 8'd0;
      end else begin
        nxt_row_s = pos_row_s + 8'd1;
      end
    end else begin
      nxt_col_s = pos_col_s + 8'd1;
      nxt_row_s = pos_row_s;
    end
  end

  assign addr_s = pos_col_s[AW-1:0];
  assign done_s = (pos_row_s >= EDGE) && (pos_col_s >= EDGE);

  // Build the incoming column (oldest row first) and the window shifted left by one column.
  always_comb begin
    win_nxt_s = win_r;
    for (int i = 0; i < NL; i++) begin
      column_s[i] = lb_r[NL-1-i][addr_s];
    end
    column_s[NL] = pix_s;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win_nxt_s[(r*WIN+c)*PIX_W +: PIX_W] = win_r[(r*WIN+c+1)*PIX_W +: PIX_W];
      end
      win_nxt_s[(r*WIN+WIN-1)*PIX_W +: PIX_W] = column_s[r];
    end
  end

  // Line buffers: each row moves down one buffer at the accepted column, new pixel enters lb0.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_r[0][addr_s] <= pix_s;
      for (int i = 1; i < NL; i++) begin
        lb_r[i][addr_s] <= lb_r[i-1][addr_s];
      end
    end
  end

  // Counters, window shift register and the registered output slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_r       <= 8'd0;
      row_r       <= 8'd0;
      win_r       <= '0;
      out_valid_r <= 1'b0;
      out_row_r   <= 8'd0;
      out_col_r   <= 8'd0;
    end else begin
      if (accept_s) begin
        col_r <= nxt_col_s;
        row_r <= nxt_row_s;
        win_r <= win_nxt_s;
      end
      if (accept_s && done_s) begin
        out_valid_r <= 1'b1;
        out_row_r   <= pos_row_s;
        out_col_r   <= pos_col_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
